// File: rtl/operand_fetch_sequencer_if.sv
// Signal bundle between the instruction controller / ALU and the operand fetch sequencer.
// The slave modport is the sequencer's view; the master modport drives it.
interface operand_fetch_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] rm;
    logic [ADDR_W-1:0] rd;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] imm;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] Ain;
    logic [DATA_W-1:0] Bin;
    logic [DATA_W-1:0] c_out;
    logic              z_out;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport slave (
        input  start, rn, rm, rd, shift, asel, bsel, imm,
        input  ext_we, ext_addr, ext_data, alu_result, alu_zero, dbg_addr,
        output Ain, Bin, c_out, z_out, busy, done, dbg_data
    );

    modport master (
        output start, rn, rm, rd, shift, asel, bsel, imm,
        output ext_we, ext_addr, ext_data, alu_result, alu_zero, dbg_addr,
        input  Ain, Bin, c_out, z_out, busy, done, dbg_data
    );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// Multi-cycle operand fetch / write-back stage around a combinational ALU:
// reads A and B from an 8-entry register file, captures C/Z, writes C back to Rd.
module operand_fetch_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic                     clk,
    input logic                     reset,
    operand_fetch_sequencer_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              z_q, done_q;
    logic              accept;

    logic [ADDR_W-1:0] rn_l, rm_l, rd_l;
    logic [1:0]        shift_l;
    logic              asel_l, bsel_l;
    logic [DATA_W-1:0] imm_l;

    function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] v,
                                                    input logic [1:0] sh);
        logic signed [DATA_W-1:0] sv;
        logic [DATA_W-1:0]        r;
        sv = v;
        case (sh)
            2'b01:   r = {v[DATA_W-2:0], 1'b0};
            2'b10:   r = {1'b0, v[DATA_W-1:1]};
            2'b11:   r = $unsigned(sv >>> 1);
            default: r = v;
        endcase
        return r;
    endfunction

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand fields are captured once per operation; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            rn_l    <= bus.rn;
            rm_l    <= bus.rm;
            rd_l    <= bus.rd;
            shift_l <= bus.shift;
            asel_l  <= bus.asel;
            bsel_l  <= bus.bsel;
            imm_l   <= bus.imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == WB);
            case (state)
                IDLE: if (bus.ext_we) regs[bus.ext_addr] <= bus.ext_data;
                RD_A: a_q <= asel_l ? '0 : regs[rn_l];
                RD_B: b_q <= bsel_l ? imm_l : shift_op(regs[rm_l], shift_l);
                EXEC: begin
                    c_q <= bus.alu_result;
                    z_q <= bus.alu_zero;
                end
                WB:   regs[rd_l] <= c_q;
                default: ;
            endcase
        end
    end

    assign bus.Ain      = a_q;
    assign bus.Bin      = b_q;
    assign bus.c_out    = c_q;
    assign bus.z_out    = z_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.dbg_data = regs[bus.dbg_addr];
endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench for operand_fetch_sequencer with an adding ALU model.
module tb_operand_fetch_sequencer;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        z;
        int          dcyc;
    } exp_t;

    exp_t sbq[$];

    operand_fetch_sequencer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    operand_fetch_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.alu_result = bus.Ain + bus.Bin;
    assign bus.alu_zero   = (bus.alu_result == 16'h0000);

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (no operation outstanding)");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("done_cycle", cyc, e.dcyc);
                check("Ain", bus.Ain, e.a);
                check("Bin", bus.Bin, e.b);
                check("c_out", bus.c_out, e.c);
                check("z_out", bus.z_out, e.z);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
        bus.ext_we   = 1'b1;
        bus.ext_addr = addr;
        bus.ext_data = data;
        tick();
        bus.ext_we   = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [2:0] addr, input logic [15:0] exp);
        bus.dbg_addr = addr;
        #1;
        check(name, bus.dbg_data, exp);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = i[2:0];
            check_reg(name, a, 16'h0000);
        end
    endtask

    // Issue one operation from IDLE, scramble the inputs while busy, return in the done cycle.
    task automatic issue(input logic [2:0] rn_i, input logic [2:0] rm_i, input logic [2:0] rd_i,
                         input logic [1:0] sh, input logic as, input logic bs, input logic [15:0] im,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec,
                         input logic ez);
        exp_t e;
        bus.rn = rn_i; bus.rm = rm_i; bus.rd = rd_i; bus.shift = sh;
        bus.asel = as; bus.bsel = bs; bus.imm = im; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e.a = ea; e.b = eb; e.c = ec; e.z = ez; e.dcyc = cyc + 4;
        sbq.push_back(e);
        bus.rn = ~rn_i; bus.rm = ~rm_i; bus.rd = ~rd_i; bus.shift = ~sh;
        bus.asel = ~as; bus.bsel = ~bs; bus.imm = ~im;
        repeat (4) tick();
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        bus.start = 0; bus.rn = 0; bus.rm = 0; bus.rd = 0; bus.shift = 0;
        bus.asel = 0; bus.bsel = 0; bus.imm = 0; bus.ext_we = 0;
        bus.ext_addr = 0; bus.ext_data = 0; bus.dbg_addr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_Ain", bus.Ain, 16'h0);
        check("rst_Bin", bus.Bin, 16'h0);
        check("rst_c_out", bus.c_out, 16'h0);
        check("rst_z_out", bus.z_out, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check_all_zero("rst_reg");

        // Reset in RD_B abandons the operation, clears A and the register file.
        ext_write(3'd1, 16'h1234);
        bus.rn = 3'd1; bus.rm = 3'd1; bus.rd = 3'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("rdb_busy", bus.busy, 1'b1);
        check("rdb_Ain", bus.Ain, 16'h1234);
        #2 reset = 1'b1;
        #1;
        check("mid_Ain", bus.Ain, 16'h0);
        check("mid_Bin", bus.Bin, 16'h0);
        check("mid_c_out", bus.c_out, 16'h0);
        check("mid_busy", bus.busy, 1'b0);
        check("mid_done", bus.done, 1'b0);
        check_all_zero("mid_reg");
        reset = 1'b0;
        repeat (6) tick();
        check("post_busy", bus.busy, 1'b0);
        check_reg("post_R2", 3'd2, 16'h0);

        // Basic add: R3 = R1 + R2.
        ext_write(3'd1, 16'h0007);
        ext_write(3'd2, 16'h0003);
        issue(3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0007, 16'h0003, 16'h000A, 1'b0);
        check_reg("R3", 3'd3, 16'h000A);

        // Shifts of R2 = 0x8002.
        ext_write(3'd2, 16'h8002);
        issue(3'd1, 3'd2, 3'd4, 2'b11, 1'b0, 1'b0, 16'h0, 16'h0007, 16'hC001, 16'hC008, 1'b0);
        issue(3'd1, 3'd2, 3'd5, 2'b10, 1'b0, 1'b0, 16'h0, 16'h0007, 16'h4001, 16'h4008, 1'b0);
        issue(3'd1, 3'd2, 3'd6, 2'b01, 1'b0, 1'b0, 16'h0, 16'h0007, 16'h0004, 16'h000B, 1'b0);
        check_reg("R4_asr", 3'd4, 16'hC008);
        check_reg("R6_lsl", 3'd6, 16'h000B);

        // Zero A and immediate B.
        issue(3'd1, 3'd2, 3'd7, 2'b00, 1'b1, 1'b1, 16'h0000, 16'h0, 16'h0, 16'h0, 1'b1);
        issue(3'd1, 3'd2, 3'd7, 2'b00, 1'b1, 1'b1, 16'h0005, 16'h0, 16'h5, 16'h5, 1'b0);
        check_reg("R7_imm", 3'd7, 16'h0005);

        // Start held high across two ops; writes and start while busy are ignored.
        bus.rn = 3'd2; bus.rm = 3'd1; bus.rd = 3'd5; bus.shift = 2'b00;
        bus.asel = 1'b0; bus.bsel = 1'b0; bus.start = 1'b1;
        tick();
        e.a = 16'h8002; e.b = 16'h0007; e.c = 16'h8009; e.z = 1'b0; e.dcyc = cyc + 4;
        sbq.push_back(e);
        bus.rn = 3'd1; bus.rm = 3'd1; bus.rd = 3'd6; bus.shift = 2'b01;
        bus.ext_we = 1'b1; bus.ext_addr = 3'd1; bus.ext_data = 16'hFFFF;
        tick();
        check("b2b_busy", bus.busy, 1'b1);
        bus.ext_we = 1'b0;
        tick();
        bus.ext_we = 1'b1; bus.ext_addr = 3'd2; bus.ext_data = 16'h0000;
        tick();
        bus.ext_addr = 3'd1;
        tick();
        bus.ext_we = 1'b0;
        check("b2b_done_idle", {bus.done, bus.busy}, 2'b10);
        tick();
        e.a = 16'h0007; e.b = 16'h000E; e.c = 16'h0015; e.z = 1'b0; e.dcyc = cyc + 4;
        sbq.push_back(e);
        bus.start = 1'b0;
        check("b2b_accepted", bus.busy, 1'b1);
        repeat (4) tick();
        check_reg("R5_b2b", 3'd5, 16'h8009);
        check_reg("R6_b2b", 3'd6, 16'h0015);
        check_reg("R1_kept", 3'd1, 16'h0007);
        check_reg("R2_kept", 3'd2, 16'h8002);

        // rd == rn, followed by a read of the updated register.
        ext_write(3'd1, 16'h0004);
        issue(3'd1, 3'd2, 3'd1, 2'b00, 1'b0, 1'b1, 16'h0004, 16'h0004, 16'h0004, 16'h0008, 1'b0);
        check_reg("R1_self", 3'd1, 16'h0008);
        issue(3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 1'b1, 16'h0000, 16'h0008, 16'h0000, 16'h0008, 1'b0);
        check_reg("R0_follow", 3'd0, 16'h0008);

        repeat (3) tick();
        check("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
